spi_adc_sequencer: RTL and testbench
====================================

# spi_adc_sequencer

Hardware sequencer that sits upstream of the 8-bit SPI master (Avalon register interface, 50 MHz, CPOL=0/CPHA=0, MSB first, one slave) and drives it in place of the CPU. It continuously scans an MCP3008-class 10-bit ADC over channels 0..NUM_CH-1. Each conversion uses three SPI bytes with slave-select held across the frame. Each result is presented to the greenhouse data path as a one-cycle `sample_valid` pulse with channel index.

## Interface
- NUM_CH, 8: channels scanned, 1..8; scan order 0..NUM_CH-1, then wraps.
- SGL, 1: 1 = single-ended, 0 = differential. Placed in the command byte.
- GAP_CYCLES, 50000: idle clk cycles between the end of one conversion and the start of the next; 0 is legal.
- TIMEOUT_CYCLES, 16384: maximum clk cycles to wait on readyfordata or dataavailable before aborting.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; scanning runs while high
- spi_select  out  1  to SPI master spi_select
- spi_mem_addr  out  3  to SPI master mem_addr
- spi_wdata  out  16  to SPI master data_from_cpu
- spi_read_n  out  1  to SPI master read_n
- spi_write_n  out  1  to SPI master write_n
- spi_rdata  in  16  from SPI master data_to_cpu
- spi_dataavailable  in  1  from SPI master (RRDY)
- spi_readyfordata  in  1  from SPI master (TRDY)
- sample_data  out  10  last conversion result
- sample_ch  out  3  channel of sample_data
- sample_valid  out  1  one-cycle pulse, new sample
- busy  out  1  high from SS_ON through SS_OFF
- timeout_err  out  1  sticky; cleared by reset, or on the rising edge of enable

## Operation
- FSM states: IDLE, SS_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, SS_OFF, EMIT, GAP.
- IDLE:
  - If enable is high, go to SS_ON.
  - If enable is low, stay in IDLE. Channel counter holds.
- SS_ON: control write, addr 3, data 0x0400 (SSO=1). Then go to TX_WAIT with byte counter = 0.
- TX_WAIT:
  - Wait for spi_readyfordata=1, then go to TX_WR.
- TX_WR: data write, addr 1, with the byte selected by the byte counter:
  - byte 0 = 0x01
  - byte 1 = {SGL, ch[2:0], 4'b0000}, zero-extended to 16 bits; for example, SGL=1, ch=5 gives 0xD0
  - byte 2 = 0x00
  - Then go to RX_WAIT.
- RX_WAIT:
  - Wait for spi_dataavailable=1, then go to RX_RD.
- RX_RD: data read, addr 0. Capture spi_rdata[7:0]:
  - byte 1: keep bits [1:0] as result[9:8]
  - byte 2: keep all 8 bits as result[7:0]
  - byte 0 is discarded
  - If byte counter = 2, go to SS_OFF. Otherwise increment the byte counter and go to TX_WAIT.
- SS_OFF: control write, addr 3, data 0x0000. Then:
  - normal completion: go to EMIT
  - abort: go to GAP
- EMIT: sample_data, sample_ch and sample_valid update in the same cycle. Channel counter advances, wrapping NUM_CH-1 → 0. Then go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Timeout: a wait counter runs in TX_WAIT and RX_WAIT. When it reaches TIMEOUT_CYCLES-1:
  - set timeout_err
  - go to SS_OFF; no sample is emitted
  - the channel counter still advances
- enable dropping mid-frame does not abort. The frame completes, then the FSM parks in IDLE after GAP.
- sample_data and sample_ch hold until the next EMIT.

## Timing
- Bus access: spi_select, spi_mem_addr and spi_wdata are driven, and spi_write_n or spi_read_n is held low, for exactly 2 consecutive cycles.
- After each access: at least 1 cycle with select=0, read_n=1, write_n=1, before any new access or any sample of the handshake inputs.
  - This covers the SPI master's registered strobes: RRDY clears and tx_holding_primed sets by the end of access cycle 2.
- Read capture: spi_rdata is sampled on the clock edge ending access cycle 2. data_to_cpu is registered one cycle after the address is applied.
- Handshake inputs are sampled only in TX_WAIT and RX_WAIT.
- Idle bus values: spi_select=0, spi_read_n=1, spi_write_n=1, spi_mem_addr=0, spi_wdata=0.
- Reset values: all bus outputs at their idle values; sample_data=0, sample_ch=0, sample_valid=0, busy=0, timeout_err=0; FSM in IDLE; all counters at 0.
- Reset mid-frame: bus outputs return to idle immediately (asynchronous). The SPI master is reset by the same reset_n.
- Fixed overhead per frame, excluding SPI waits: 1 cycle from enable to SS_ON, plus 8 accesses × 3 cycles, plus EMIT 1 cycle.

## Test plan
- Reset: hold reset_n=0 mid-TX_WR → all outputs at reset values in the same cycle; after release, the first access is a control write of 0x0400 to addr 3.
- Single channel (NUM_CH=1, SGL=1, ch 0): bench MISO returns 0xFF, 0x02, 0x5A → writes 0x01, 0x80, 0x00; sample_data=0x25A, sample_ch=0, one-cycle sample_valid; SS_n stays low across all 3 bytes.
- Scan wrap (NUM_CH=6): 7 frames → sample_ch sequence 0, 1, 2, 3, 4, 5, 0; byte 1 for ch 5 = 0xD0.
- Bus protocol checker: every access is exactly 2 cycles of strobe low followed by ≥1 idle cycle; the SPI master never sets TOE or ROE over 20 frames.
- Timeout (TIMEOUT_CYCLES=100): force dataavailable stuck at 0 → timeout_err=1 after 100 cycles in RX_WAIT; addr 3 written with 0x0000; no sample_valid; next frame uses the next channel.
- enable deasserted during byte 1 → the frame completes with one sample_valid, then the FSM stays in IDLE and the bus stays idle.

Source files
------------

// File: rtl/spi_adc_sequencer.sv
// rtl/spi_adc_sequencer.sv - scans an MCP3008-class ADC through the 8-bit SPI master register port
// Each conversion is one SSO-held frame of three bytes; results leave as a one-cycle sample_valid pulse.
module spi_adc_sequencer #(
    parameter int unsigned NUM_CH         = 8,
    parameter logic        SGL            = 1'b1,
    parameter int unsigned GAP_CYCLES     = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        spi_select,
    output logic [2:0]  spi_mem_addr,
    output logic [15:0] spi_wdata,
    output logic        spi_read_n,
    output logic        spi_write_n,
    input  logic [15:0] spi_rdata,
    input  logic        spi_dataavailable,
    input  logic        spi_readyfordata,
    output logic [9:0]  sample_data,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        IDLE, SS_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, SS_OFF, EMIT, GAP
    } state_t;

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [1:0]  byte_q, byte_d;
    logic [2:0]  ch_q, ch_d, ch_next;
    logic [31:0] wait_q, wait_d;
    logic [31:0] gap_q, gap_d;
    logic [9:0]  result_q, result_d;
    logic        abort_q, abort_d;
    logic        err_q, err_d;
    logic        en_q, en_d;
    logic        sel_q, sel_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic [9:0]  sdata_q, sdata_d;
    logic [2:0]  sch_q, sch_d;
    logic        svalid_q, svalid_d;
    logic        busy_q, busy_d;
    logic        unused_rdata;

    assign unused_rdata = ^spi_rdata[15:8];
    assign ch_next = (ch_q == LAST_CH) ? 3'd0 : ch_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        ph_d     = 2'd0;
        byte_d   = byte_q;
        ch_d     = ch_q;
        wait_d   = 32'd0;
        gap_d    = 32'd0;
        result_d = result_q;
        abort_d  = abort_q;
        en_d     = enable;
        err_d    = (enable && !en_q) ? 1'b0 : err_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SS_ON;
                    abort_d = 1'b0;
                end
            end
            SS_ON: begin
                if (ph_q == 2'd2) begin
                    state_d = TX_WAIT;
                    byte_d  = 2'd0;
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end
            TX_WAIT: begin
                if (spi_readyfordata) begin
                    state_d = TX_WR;
                end else if (wait_q == TIMEOUT_CYCLES - 1) begin
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = SS_OFF;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            TX_WR: begin
                if (ph_q == 2'd2) state_d = RX_WAIT;
                else              ph_d = ph_q + 2'd1;
            end
            RX_WAIT: begin
                if (spi_dataavailable) begin
                    state_d = RX_RD;
                end else if (wait_q == TIMEOUT_CYCLES - 1) begin
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = SS_OFF;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            RX_RD: begin
                // data_to_cpu is valid by the second strobe cycle
                if (ph_q == 2'd1) begin
                    if (byte_q == 2'd1) result_d[9:8] = spi_rdata[1:0];
                    if (byte_q == 2'd2) result_d[7:0] = spi_rdata[7:0];
                end
                if (ph_q == 2'd2) begin
                    if (byte_q == 2'd2) begin
                        state_d = SS_OFF;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = TX_WAIT;
                    end
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end
            SS_OFF: begin
                if (ph_q == 2'd2) begin
                    if (abort_q) begin
                        ch_d    = ch_next;
                        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        state_d = EMIT;
                    end
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end
            EMIT: begin
                ch_d    = ch_next;
                state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_q == GAP_CYCLES - 1) state_d = IDLE;
                else                         gap_d = gap_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they leave a flop aligned with the state
    always_comb begin
        sel_d    = 1'b0;
        addr_d   = 3'd0;
        wdata_d  = 16'h0000;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        busy_d   = (state_d == SS_ON) || (state_d == TX_WAIT) || (state_d == TX_WR) ||
                   (state_d == RX_WAIT) || (state_d == RX_RD) || (state_d == SS_OFF);
        svalid_d = (state_d == EMIT);
        sdata_d  = (state_d == EMIT) ? result_d : sdata_q;
        sch_d    = (state_d == EMIT) ? ch_q : sch_q;
        if (ph_d != 2'd2) begin
            case (state_d)
                SS_ON: begin
                    sel_d   = 1'b1;
                    addr_d  = 3'd3;
                    wdata_d = 16'h0400;
                    wr_n_d  = 1'b0;
                end
                TX_WR: begin
                    sel_d  = 1'b1;
                    addr_d = 3'd1;
                    wr_n_d = 1'b0;
                    case (byte_d)
                        2'd0:    wdata_d = 16'h0001;
                        2'd1:    wdata_d = {8'h00, SGL, ch_q, 4'b0000};
                        default: wdata_d = 16'h0000;
                    endcase
                end
                RX_RD: begin
                    sel_d  = 1'b1;
                    rd_n_d = 1'b0;
                end
                SS_OFF: begin
                    sel_d  = 1'b1;
                    addr_d = 3'd3;
                    wr_n_d = 1'b0;
                end
                default: sel_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ph_q     <= 2'd0;
            byte_q   <= 2'd0;
            ch_q     <= 3'd0;
            wait_q   <= 32'd0;
            gap_q    <= 32'd0;
            result_q <= 10'd0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            sel_q    <= 1'b0;
            addr_q   <= 3'd0;
            wdata_q  <= 16'h0000;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            sdata_q  <= 10'd0;
            sch_q    <= 3'd0;
            svalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            byte_q   <= byte_d;
            ch_q     <= ch_d;
            wait_q   <= wait_d;
            gap_q    <= gap_d;
            result_q <= result_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            en_q     <= en_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            sdata_q  <= sdata_d;
            sch_q    <= sch_d;
            svalid_q <= svalid_d;
            busy_q   <= busy_d;
        end
    end

    assign spi_select   = sel_q;
    assign spi_mem_addr = addr_q;
    assign spi_wdata    = wdata_q;
    assign spi_read_n   = rd_n_q;
    assign spi_write_n  = wr_n_q;
    assign sample_data  = sdata_q;
    assign sample_ch    = sch_q;
    assign sample_valid = svalid_q;
    assign busy         = busy_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// tb/tb_spi_adc_sequencer.sv - self-checking bench for spi_adc_sequencer
// Behavioural SPI master model, bus protocol monitor and write/sample scoreboards.
module tb_spi_adc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        spi_select, spi_read_n, spi_write_n;
    logic [2:0]  spi_mem_addr;
    logic [15:0] spi_wdata, spi_rdata;
    logic        spi_dataavailable, spi_readyfordata;
    logic [9:0]  sample_data;
    logic [2:0]  sample_ch;
    logic        sample_valid, busy, timeout_err;

    always #5 clk = ~clk;

    spi_adc_sequencer #(
        .NUM_CH(6), .SGL(1'b1), .GAP_CYCLES(3), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .spi_select(spi_select), .spi_mem_addr(spi_mem_addr), .spi_wdata(spi_wdata),
        .spi_read_n(spi_read_n), .spi_write_n(spi_write_n), .spi_rdata(spi_rdata),
        .spi_dataavailable(spi_dataavailable), .spi_readyfordata(spi_readyfordata),
        .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    logic [18:0] exp_wr[$];
    logic [7:0]  miso_q[$];
    logic [12:0] exp_smp[$];

    // SPI master model: TRDY drops for a byte time after a data write, RRDY rises with the MISO byte
    logic       m_trdy, m_rrdy, m_wr_prev, m_rd_prev;
    logic       m_stall = 1'b0;
    logic [7:0] m_rdata;
    int         m_cnt;
    logic       toe = 1'b0, roe = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_trdy <= 1'b1; m_rrdy <= 1'b0; m_rdata <= 8'h00; m_cnt <= 0;
            m_wr_prev <= 1'b0; m_rd_prev <= 1'b0;
        end else begin
            m_wr_prev <= !spi_write_n;
            m_rd_prev <= !spi_read_n;
            if (!spi_write_n && !m_wr_prev && spi_select && spi_mem_addr == 3'd1) begin
                if (!m_trdy) toe <= 1'b1;
                m_trdy <= 1'b0;
                m_cnt  <= 6;
            end else if (m_cnt == 1) begin
                m_cnt  <= 0;
                m_trdy <= 1'b1;
                if (!m_stall) begin
                    if (m_rrdy) roe <= 1'b1;
                    m_rrdy <= 1'b1;
                    if (miso_q.size() > 0) m_rdata <= miso_q.pop_front();
                    else                   m_rdata <= 8'h00;
                end
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
            if (!spi_read_n && !m_rd_prev && spi_select && spi_mem_addr == 3'd0) m_rrdy <= 1'b0;
        end
    end

    assign spi_rdata         = {8'h00, m_rdata};
    assign spi_readyfordata  = m_trdy;
    assign spi_dataavailable = m_rrdy;

    // Protocol monitor and scoreboards
    int          run = 0;
    logic [18:0] prev_acc;
    logic [12:0] smp;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            run = 0;
            prev_valid = 1'b0;
        end else begin
            if (!spi_write_n || !spi_read_n) begin
                run++;
                if (run == 1) begin
                    check("acc_select", spi_select, 1);
                    if (!spi_write_n) begin
                        if (exp_wr.size() == 0) check("unexpected_write", {spi_mem_addr, spi_wdata}, 19'h7ffff);
                        else check("write", {spi_mem_addr, spi_wdata}, exp_wr.pop_front());
                    end else begin
                        check("read_addr", spi_mem_addr, 0);
                    end
                    prev_acc = {spi_mem_addr, spi_wdata};
                end else begin
                    check("acc_stable", {spi_mem_addr, spi_wdata}, prev_acc);
                end
            end else begin
                if (run != 0) begin
                    check("acc_len", run, 2);
                    check("acc_idle_sel", spi_select, 0);
                end
                run = 0;
            end
            if (sample_valid) begin
                check("valid_pulse", prev_valid, 0);
                if (exp_smp.size() == 0) begin
                    check("unexpected_sample", {sample_ch, sample_data}, 13'h1fff);
                end else begin
                    smp = exp_smp.pop_front();
                    check("sample_ch", sample_ch, smp[12:10]);
                    check("sample_data", sample_data, smp[9:0]);
                end
            end
            prev_valid = sample_valid;
        end
    end

    typedef struct {
        logic [7:0] m0, m1, m2, b1;
        logic [9:0] data;
        logic [2:0] ch;
    } vec_t;

    vec_t tbl[7];

    task automatic push_frame(input logic [2:0] ch, input logic [7:0] b1, input logic [7:0] m0,
                              input logic [7:0] m1, input logic [7:0] m2, input logic [9:0] data);
        exp_wr.push_back({3'd3, 16'h0400});
        exp_wr.push_back({3'd1, 16'h0001});
        exp_wr.push_back({3'd1, 8'h00, b1});
        exp_wr.push_back({3'd1, 16'h0000});
        exp_wr.push_back({3'd3, 16'h0000});
        miso_q.push_back(m0);
        miso_q.push_back(m1);
        miso_q.push_back(m2);
        exp_smp.push_back({ch, data});
    endtask

    task automatic push_model(input logic [2:0] ch, input logic [7:0] m0, input logic [7:0] m1,
                              input logic [7:0] m2);
        push_frame(ch, {1'b1, ch, 4'b0000}, m0, m1, m2, {m1[1:0], m2});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_smp.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_smp.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_select"}, spi_select, 0);
        check({tag, "_addr"}, spi_mem_addr, 0);
        check({tag, "_wdata"}, spi_wdata, 0);
        check({tag, "_read_n"}, spi_read_n, 1);
        check({tag, "_write_n"}, spi_write_n, 1);
        check({tag, "_sdata"}, sample_data, 0);
        check({tag, "_sch"}, sample_ch, 0);
        check({tag, "_svalid"}, sample_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_terr"}, timeout_err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [7:0] r0, r1, r2;

        tbl[0] = '{8'hFF, 8'h02, 8'h5A, 8'h80, 10'h25A, 3'd0};
        tbl[1] = '{8'h00, 8'h03, 8'hFF, 8'h90, 10'h3FF, 3'd1};
        tbl[2] = '{8'hFF, 8'h00, 8'h00, 8'hA0, 10'h000, 3'd2};
        tbl[3] = '{8'h12, 8'h01, 8'h34, 8'hB0, 10'h134, 3'd3};
        tbl[4] = '{8'hAA, 8'hFE, 8'hC3, 8'hC0, 10'h2C3, 3'd4};
        tbl[5] = '{8'h55, 8'h7D, 8'h81, 8'hD0, 10'h181, 3'd5};
        tbl[6] = '{8'h00, 8'h02, 8'h80, 8'h80, 10'h280, 3'd0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_enable_busy", busy, 0);
        check("idle_no_enable_sel", spi_select, 0);

        for (int i = 0; i < 7; i++)
            push_frame(tbl[i].ch, tbl[i].b1, tbl[i].m0, tbl[i].m1, tbl[i].m2, tbl[i].data);
        for (int i = 7; i < 20; i++) begin
            r0 = 8'($urandom_range(0, 255));
            r1 = 8'($urandom_range(0, 255));
            r2 = 8'($urandom_range(0, 255));
            push_model(3'(i % 6), r0, r1, r2);
        end
        enable = 1'b1;
        wait_drain("scan_drain", 5000);

        // Timeout: frame on ch 2 never gets RRDY
        check("terr_before", timeout_err, 0);
        m_stall = 1'b1;
        exp_wr.push_back({3'd3, 16'h0400});
        exp_wr.push_back({3'd1, 16'h0001});
        exp_wr.push_back({3'd3, 16'h0000});
        n = 0;
        while (!(!spi_write_n && spi_mem_addr == 3'd1) && n < 500) begin @(negedge clk); n++; end
        while (!spi_write_n && n < 500) begin @(negedge clk); n++; end
        check("to_write_seen", (n < 500), 1);
        n = 0;
        while (!timeout_err && n < 500) begin @(negedge clk); n++; end
        check("timeout_cycles", n, 101);
        m_stall = 1'b0;
        push_model(3'd3, 8'hFF, 8'h01, 8'h77);

        // enable drops during byte 1 of the ch 3 frame
        n = 0;
        while (!(!spi_write_n && spi_mem_addr == 3'd1 && spi_wdata == 16'h00B0) && n < 500) begin
            @(negedge clk); n++;
        end
        check("byte1_seen", (n < 500), 1);
        enable = 1'b0;
        wait_drain("drop_drain", 500);
        check("terr_sticky", timeout_err, 1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (spi_select || busy || !spi_write_n || !spi_read_n) bad++;
        end
        check("parked_idle", bad, 0);
        check("hold_data", sample_data, 10'h177);
        check("hold_ch", sample_ch, 3);

        // Re-enable clears the sticky error; then reset mid-TX_WR on the ch 4 frame
        exp_wr.push_back({3'd3, 16'h0400});
        exp_wr.push_back({3'd1, 16'h0001});
        enable = 1'b1;
        @(negedge clk);
        check("terr_cleared", timeout_err, 0);
        n = 0;
        while (!(!spi_write_n && spi_mem_addr == 3'd1) && n < 500) begin @(negedge clk); n++; end
        check("txwr_seen", (n < 500), 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async");
        check("wr_consumed", exp_wr.size(), 0);
        miso_q.delete();
        repeat (2) @(negedge clk);
        push_model(3'd0, 8'h00, 8'h03, 8'hC4);
        reset_n = 1'b1;
        n = 0;
        while (!spi_select && n < 100) begin @(negedge clk); n++; end
        check("first_access", {spi_mem_addr, spi_wdata, spi_write_n}, {3'd3, 16'h0400, 1'b0});
        enable = 1'b0;
        wait_drain("post_reset_drain", 500);
        check("post_reset_data", sample_data, 10'h3C4);

        repeat (10) @(negedge clk);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("no_toe", toe, 0);
        check("no_roe", roe, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
